// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions: opcode constants (also used by control_unit), stage FSM encoding, default width.
// Latency: n/a (declarations only). Backpressure: n/a.
// Build option: ALU_FAST_SHIFT_EN selects the barrel shifter in the exec stage.
package mips_alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SLL  = 3'b110;
    localparam logic [2:0] ALU_SRL  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [2:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for all single-cycle ops; barrel shift only when ALU_FAST_SHIFT_EN is defined.
// Latency: 0 cycles (pure logic). Backpressure: none, the enclosing stage owns flow control.
// Without ALU_FAST_SHIFT_EN a shift returns op b unchanged, which is the shamt == 0 answer.
module alu_core
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALU_FAST_SHIFT_EN
    input  logic [4:0]       shamt,
`endif
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (alu_sel)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
`else
            ALU_SLL,
            ALU_SRL:  y = b;
`endif
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered R-type execute stage with valid/ready handshake toward write-back.
// Latency: 1 edge; shifts take shamt+1 edges unless ALU_FAST_SHIFT_EN builds the barrel shifter.
// Backpressure: a held result stalls in_ready until out_ready; consume+accept in one cycle is allowed.
module alu_exec_stage
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       select_bits_ALU,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    input  logic [4:0]       dest_reg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       out_dest,
    output logic             zero
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       dest_q, dest_d;
    logic [WIDTH-1:0] core_y;
    logic             accept;
    logic             start_iter;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_sel (select_bits_ALU),
        .a       (op_a),
        .b       (op_b),
`ifdef ALU_FAST_SHIFT_EN
        .shamt   (shamt),
`endif
        .y       (core_y)
    );

    assign accept = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
    assign start_iter = 1'b0;
`else
    logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
    logic [4:0]       cnt_q, cnt_d;
    logic             dir_q, dir_d;

    assign start_iter = accept && is_shift(select_bits_ALU) && (shamt != 5'd0);
    // dir_q high means logical right shift (SRL)
    assign shifted    = dir_q ? (sreg_q >> 1) : (sreg_q << 1);

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        if (start_iter) begin
            sreg_d = op_b;
            cnt_d  = shamt;
            dir_d  = (select_bits_ALU == ALU_SRL);
        end else if (state_q == ST_SHIFT) begin
            sreg_d = shifted;
            cnt_d  = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    state_d = start_iter ? ST_SHIFT : ST_HOLD;
                end else if (state_q == ST_HOLD && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            ST_SHIFT: begin
                if (cnt_q == 5'd1) begin
                    state_d = ST_HOLD;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_HOLD: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Result only moves on entry to HOLD, so it is stable for as long as it is offered.
    always_comb begin
        result_d = result_q;
        dest_d   = dest_q;
        if (accept) begin
            dest_d = dest_reg;
            if (!start_iter) begin
                result_d = core_y;
            end
        end
`ifndef ALU_FAST_SHIFT_EN
        else if (state_q == ST_SHIFT && cnt_q == 5'd1) begin
            result_d = shifted;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            dest_q   <= '0;
        end else begin
            result_q <= result_d;
            dest_q   <= dest_d;
        end
    end

    assign result   = result_q;
    assign out_dest = dest_q;
    assign zero     = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed vector table, hand-written corner sequences, random ops vs a reference model.
module tb_alu_exec_stage;
    import mips_alu_pkg::*;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic [31:0] op_a, op_b;
    logic [4:0]  shamt, dest_reg;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic [4:0]  out_dest;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .select_bits_ALU (sel),
        .op_a            (op_a),
        .op_b            (op_b),
        .shamt           (shamt),
        .dest_reg        (dest_reg),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .result          (result),
        .out_dest        (out_dest),
        .zero            (zero)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, b,
                                            input logic [4:0] sh);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ~(a | b);
            3'd5: return (a < b) ? 32'd1 : 32'd0;
            3'd6: return b << sh;
            default: return b >> sh;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [4:0] sh);
        if (!FAST && (op == 3'd6 || op == 3'd7) && sh != 5'd0) return int'(sh) + 1;
        return 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, wait for its result, optionally stall, then consume it.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, input logic [4:0] sh,
                          input logic [4:0] dst, input int stall,
                          output logic [31:0] r, output logic [4:0] d, output logic z,
                          output int lat, output int bad);
        bad = 0;
        sel = op; op_a = a; op_b = b; shamt = sh; dest_reg = dst;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        if (!in_ready) bad++;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (in_ready) bad++;
            tick();
            lat++;
        end
        r = result; d = out_dest; z = zero;
        for (int s = 0; s < stall; s++) begin
            if (in_ready) bad++;
            tick();
            if (result !== r || out_dest !== d || !out_valid) bad++;
        end
        out_ready = 1'b1;
        tick();
        if (out_valid) bad++;
        out_ready = 1'b0;
    endtask

    vec_t        vecs[11];
    logic [31:0] r;
    logic [4:0]  d;
    logic        z;
    int          lat, bad;

    initial begin
        logic [31:0] b2b_exp[4];
        logic [2:0]  b2b_op[4];
        int          seen;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0};
        vecs[1]  = '{3'd1, 32'd10,        32'd3,         5'd0,  32'd7};
        vecs[2]  = '{3'd2, 32'd5,         32'd7,         5'd0,  32'd5};
        vecs[3]  = '{3'd3, 32'd5,         32'd7,         5'd0,  32'd7};
        vecs[4]  = '{3'd4, 32'd5,         32'd7,         5'd0,  32'hFFFF_FFF8};
        vecs[5]  = '{3'd5, 32'd5,         32'd7,         5'd0,  32'd1};
        vecs[6]  = '{3'd5, 32'd7,         32'd5,         5'd0,  32'd0};
        vecs[7]  = '{3'd6, 32'h0,         32'h1,         5'd31, 32'h8000_0000};
        vecs[8]  = '{3'd7, 32'h0,         32'h8000_0000, 5'd0,  32'h8000_0000};
        vecs[9]  = '{3'd7, 32'h0,         32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[10] = '{3'd6, 32'h0,         32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = '0; op_a = '0; op_b = '0; shamt = '0; dest_reg = '0;
        tick(); tick();
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", {31'd0, zero}, 32'd1);
        chk("reset out_dest", {27'd0, out_dest}, 32'd0);
        rst_n = 1'b1;
        chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, 5'(i + 1), 0, r, d, z, lat, bad);
            chk($sformatf("vec%0d result", i), r, vecs[i].exp);
            chk($sformatf("vec%0d zero", i), {31'd0, z}, {31'd0, (vecs[i].exp == 32'd0)});
            chk($sformatf("vec%0d dest", i), {27'd0, d}, 32'(i + 1));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(ref_lat(vecs[i].op, vecs[i].sh)));
            chk($sformatf("vec%0d handshake", i), 32'(bad), 32'd0);
        end

        // Back-to-back single-cycle ops: one result per edge.
        b2b_op  = '{3'd2, 3'd3, 3'd4, 3'd5};
        b2b_exp = '{32'd5, 32'd7, 32'hFFFF_FFF8, 32'd1};
        op_a = 32'd5; op_b = 32'd7; shamt = '0; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = b2b_op[i]; dest_reg = 5'(10 + i);
            tick();
            chk($sformatf("b2b%0d valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("b2b%0d result", i), result, b2b_exp[i]);
            chk($sformatf("b2b%0d dest", i), {27'd0, out_dest}, 32'(10 + i));
        end
        in_valid = 1'b0;
        tick();
        chk("b2b drain valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: SUB held 5 cycles, then consume and accept in the same edge.
        sel = 3'd1; op_a = 32'd10; op_b = 32'd3; dest_reg = 5'd4; out_ready = 1'b0; in_valid = 1'b1;
        tick();
        sel = 3'd0; op_a = 32'd1; op_b = 32'd2; dest_reg = 5'd9;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d result", i), result, 32'd7);
            chk($sformatf("bp%0d in_ready", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d valid", i), {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp next result", result, 32'd3);
        chk("bp next dest", {27'd0, out_dest}, 32'd9);
        chk("bp next valid", {31'd0, out_valid}, 32'd1);
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a long shift.
        sel = 3'd7; op_a = '0; op_b = 32'hFFFF_FFFF; shamt = 5'd20; dest_reg = 5'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst valid", {31'd0, out_valid}, 32'd0);
        chk("midrst result", result, 32'd0);
        chk("midrst zero", {31'd0, zero}, 32'd1);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst dest", {27'd0, out_dest}, 32'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("midrst stale result", 32'(seen), 32'd0);
        run_op(3'd0, 32'd2, 32'd3, 5'd0, 5'd1, 0, r, d, z, lat, bad);
        chk("midrst recover", r, 32'd5);

        // Random ops with random output stalls against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            logic [4:0]  rsh, rd;
            int          st;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rsh = 5'($urandom_range(0, 31));
            rd  = 5'($urandom_range(0, 31));
            st  = $urandom_range(0, 3);
            run_op(rop, ra, rb, rsh, rd, st, r, d, z, lat, bad);
            chk($sformatf("rnd%0d result op%0d", i, rop), r, ref_alu(rop, ra, rb, rsh));
            chk($sformatf("rnd%0d zero", i), {31'd0, z}, {31'd0, (ref_alu(rop, ra, rb, rsh) == 32'd0)});
            chk($sformatf("rnd%0d dest", i), {27'd0, d}, {27'd0, rd});
            chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(ref_lat(rop, rsh)));
            chk($sformatf("rnd%0d handshake", i), 32'(bad), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
